// File: rtl/instr_ram_loader.sv
// instr_ram_loader
//   Writer-side master for port B of the instruction RAM. Streams 32-bit
//   instruction words (valid/ready) into consecutive word addresses starting
//   at BASE_ADDR and holds the CPU in reset while the image is loading.
//
//   Optional feature macro: READBACK_VERIFY_EN
//     defined   : every written word is read back (RD) and compared (CMP);
//                 a mismatch aborts the load into ERROR.
//     undefined : back-to-back writes, error only flags word_count > MAX_WORDS.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, word_count begin a load of word_count words (ignored while busy)
//   s_valid, s_data   instruction word stream
//   s_ready           loader accepts s_data this cycle
//   ram_web           port-B write enable
//   ram_addrb         port-B word address (byte address [31:2])
//   ram_dinb          port-B write data
//   ram_doutb         port-B read data, one cycle after the address
//   busy, cpu_hold    load in progress / CPU held in reset (identical)
//   done, error       load completed / load aborted (levels)
//   words_written     words committed in the current load

module instr_ram_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 4096,
    parameter int          CNT_W     = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    output logic             s_ready,
    output logic             ram_web,
    output logic [29:0]      ram_addrb,
    output logic [31:0]      ram_dinb,
    input  logic [31:0]      ram_doutb,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_written
);

    localparam logic [29:0]      BASE_WADDR = BASE_ADDR[31:2];
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
`ifdef READBACK_VERIFY_EN
        S_RD,
        S_CMP,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] index, index_d;
    logic [CNT_W-1:0] count, count_d;
    logic [CNT_W-1:0] index_inc;

`ifdef READBACK_VERIFY_EN
    logic [31:0] hold_data, hold_data_d;
`else
    // Read data is only consulted by the verify path.
    logic unused_doutb;
    assign unused_doutb = ^ram_doutb;
`endif

    assign index_inc = index + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            index <= '0;
            count <= '0;
`ifdef READBACK_VERIFY_EN
            hold_data <= '0;
`endif
        end else begin
            state <= state_d;
            index <= index_d;
            count <= count_d;
`ifdef READBACK_VERIFY_EN
            hold_data <= hold_data_d;
`endif
        end
    end

    always_comb begin
        state_d  = state;
        index_d  = index;
        count_d  = count;
`ifdef READBACK_VERIFY_EN
        hold_data_d = hold_data;
`endif
        s_ready  = 1'b0;
        ram_web  = 1'b0;
        ram_dinb = '0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                done  = (state == S_DONE);
                error = (state == S_ERROR);
                if (start) begin
                    index_d = '0;
                    count_d = word_count;
                    if (word_count == '0)
                        state_d = S_DONE;
                    else if (word_count > MAX_CNT)
                        state_d = S_ERROR;
                    else
                        state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                busy     = 1'b1;
                s_ready  = 1'b1;
                ram_dinb = s_data;
                ram_web  = s_valid;
                if (s_valid) begin
`ifdef READBACK_VERIFY_EN
                    hold_data_d = s_data;
                    state_d     = S_RD;
`else
                    index_d = index_inc;
                    if (index_inc == count)
                        state_d = S_DONE;
`endif
                end
            end

`ifdef READBACK_VERIFY_EN
            // Address stays put so the RAM registers the word just written.
            S_RD: begin
                busy    = 1'b1;
                state_d = S_CMP;
            end

            S_CMP: begin
                busy = 1'b1;
                if (ram_doutb != hold_data) begin
                    state_d = S_ERROR;
                end else begin
                    index_d = index_inc;
                    state_d = (index_inc == count) ? S_DONE : S_WRITE;
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    // Word address wraps modulo 2^30; the RAM drops out-of-window writes.
    assign ram_addrb     = BASE_WADDR + 30'(index);
    assign cpu_hold      = busy;
    assign words_written = index;

endmodule

// File: tb/tb_instr_ram_loader.sv
module tb_instr_ram_loader;

    localparam int CNT_W = 13;
`ifdef READBACK_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main DUT, BASE_ADDR = 0
    logic             start = 1'b0, s_valid = 1'b0;
    logic [CNT_W-1:0] word_count = '0;
    logic [31:0]      s_data = '0;
    logic             s_ready, ram_web, busy, cpu_hold, done, error;
    logic [29:0]      ram_addrb;
    logic [31:0]      ram_dinb, ram_doutb;
    logic [CNT_W-1:0] words_written;

    // second DUT whose window lies outside the RAM
    logic             start2 = 1'b0, s_valid2 = 1'b0;
    logic [CNT_W-1:0] word_count2 = '0;
    logic [31:0]      s_data2 = '0;
    logic             s_ready2, ram_web2, busy2, cpu_hold2, done2, error2;
    logic [29:0]      ram_addrb2;
    logic [31:0]      ram_dinb2, ram_doutb2;
    logic [CNT_W-1:0] words_written2;

    instr_ram_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(4096), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dinb(ram_dinb), .ram_doutb(ram_doutb),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_written(words_written));

    instr_ram_loader #(.BASE_ADDR(32'h0001_0000), .MAX_WORDS(4096), .CNT_W(CNT_W)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .word_count(word_count2),
        .s_valid(s_valid2), .s_data(s_data2), .s_ready(s_ready2),
        .ram_web(ram_web2), .ram_addrb(ram_addrb2), .ram_dinb(ram_dinb2), .ram_doutb(ram_doutb2),
        .busy(busy2), .cpu_hold(cpu_hold2), .done(done2), .error(error2),
        .words_written(words_written2));

    // 4096-word RAM models, read-first, registered read, out-of-window reads 0
    logic [31:0] mem  [0:4095];
    logic [31:0] mem2 [0:4095];
    always @(posedge clk) begin
        if (ram_web && ram_addrb[29:12] == '0) mem[ram_addrb[11:0]] <= ram_dinb;
        ram_doutb <= (ram_addrb[29:12] == '0) ? mem[ram_addrb[11:0]] : 32'h0;
        if (ram_web2 && ram_addrb2[29:12] == '0) mem2[ram_addrb2[11:0]] <= ram_dinb2;
        ram_doutb2 <= (ram_addrb2[29:12] == '0) ? mem2[ram_addrb2[11:0]] : 32'h0;
    end

    // write monitor: every port-B write the DUT issues
    logic [61:0] obs_q[$];
    int          wr2_cnt = 0;
    logic [29:0] wr2_addr = '0;
    always @(negedge clk) begin
        if (ram_web) obs_q.push_back({ram_addrb, ram_dinb});
        if (ram_web2) begin
            wr2_cnt  <= wr2_cnt + 1;
            wr2_addr <= ram_addrb2;
        end
    end

    int          npass = 0, ntot = 0;
    int          obs_rd = 0;
    logic [61:0] exp_q[$];
    logic [31:0] wds[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ntot++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // Drive one load of n words from wds; optional bubble, start glitch, abort.
    task automatic run_load(input int n, input int gap_at, input int glitch_at,
                            input int abort_at, input int exp_cyc);
        int k, cyc, gap_rem, nlow, obs0;
        bit hs, fin, gap_done, in_gap, glitched;
        k = 0; cyc = 0; gap_rem = 0; nlow = 0; fin = 0;
        gap_done = 0; in_gap = 0; glitched = 0;
        exp_q.delete();
        obs0 = obs_q.size();
        @(posedge clk); #1;
        start = 1'b1; word_count = CNT_W'(n); s_valid = 1'b0;
        for (int it = 0; it < n * 4 + 40 && !fin; it++) begin
            @(negedge clk);
            hs = s_valid && s_ready;
            if (busy && !s_ready) nlow++;
            if (in_gap) begin
                chk("gap_web", ram_web, 0);
                chk("gap_addr", ram_addrb, gap_at);
            end
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (it == 0) begin
                chk("busy_on", busy, 1);
                chk("hold_on", cpu_hold, 1);
            end
            if (hs) begin
                exp_q.push_back({30'(k), wds[k]});
                k++;
            end
            if (k == glitch_at && !glitched) begin
                start = 1'b1; word_count = CNT_W'(2); glitched = 1;
            end
            if (abort_at >= 0 && k == abort_at) begin
                chk("busy_pre_abort", busy, 1);
                #2 rst_n = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_hold", cpu_hold, 0);
                chk("abort_web", ram_web, 0);
                chk("abort_ready", s_ready, 0);
                chk("abort_ww", words_written, 0);
                chk("abort_done", done, 0);
                chk("abort_err", error, 0);
                fin = 1;
            end else if (done || error) begin
                fin = 1;
            end else begin
                if (!gap_done && k == gap_at && s_ready) begin
                    gap_rem = 3; gap_done = 1;
                end
                in_gap = (gap_rem > 0);
                if (gap_rem > 0) begin
                    gap_rem--;
                    s_valid = 1'b0;
                end else begin
                    s_valid = (k < n);
                    s_data  = (k < n) ? wds[k] : 32'h0;
                end
            end
        end
        s_valid = 1'b0; start = 1'b0;
        chk("finished", fin, 1);
        if (abort_at < 0) begin
            chk("cycles", cyc, exp_cyc);
            chk("ready_low", nlow, VER ? 2 * n : 0);
            chk("done", done, 1);
            chk("error", error, 0);
            chk("ww", words_written, n);
            chk("busy_off", busy, 0);
            chk("hold_off", cpu_hold, 0);
            chk("exp_cnt", exp_q.size(), n);
        end
        // scoreboard: accepted words against observed RAM writes
        chk("wr_cnt", obs_q.size() - obs0, exp_q.size());
        obs_rd = obs0;
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            chk("wr", obs_q[obs_rd], exp_q.pop_front());
            obs_rd++;
        end
        if (abort_at < 0)
            for (int i = 0; i < n; i++) chk("ram", mem[i], wds[i]);
    endtask

    initial begin
        logic [31:0] prog [7];
        int n0;
        prog = '{32'h00000293, 32'h00000313, 32'h06500393, 32'h00530333,
                 32'h00128293, 32'hfe729ce3, 32'h00130313};

        // reset values
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        chk("rst_ww", words_written, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_web", ram_web, 0);
        chk("rst_addr", ram_addrb, 0);
        chk("rst_din", ram_dinb, 0);
        chk("rst_addr2", ram_addrb2, 30'h0000_4000);
        #10 rst_n = 1'b1;

        // basic load
        wds.delete();
        foreach (prog[i]) wds.push_back(prog[i]);
        run_load(7, -1, -1, -1, VER ? 22 : 8);

        // bubble of three cycles before word index 3
        run_load(7, 3, -1, -1, VER ? 25 : 11);

        // start pulse while busy is ignored
        run_load(7, -1, 2, -1, VER ? 22 : 8);

        // word_count = 0
        n0 = obs_q.size();
        @(posedge clk); #1 start = 1'b1; word_count = '0;
        @(posedge clk); #1 start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_ww", words_written, 0);
        @(posedge clk); #1;
        chk("zero_nowr", obs_q.size() - n0, 0);

        // word_count = 4097
        @(posedge clk); #1 start = 1'b1; word_count = CNT_W'(4097);
        @(posedge clk); #1 start = 1'b0;
        chk("ovf_err", error, 1);
        chk("ovf_done", done, 0);
        chk("ovf_busy", busy, 0);
        chk("ovf_ww", words_written, 0);
        @(posedge clk); #1;
        chk("ovf_nowr", obs_q.size() - n0, 0);

        // full-depth load, last write at word 12'hFFF
        wds.delete();
        for (int i = 0; i < 4096; i++) wds.push_back((i * 32'h0101_0101) ^ 32'h13);
        run_load(4096, -1, -1, -1, VER ? 1 + 3 * 4096 : 4097);
        chk("last_addr", obs_q[obs_q.size() - 1][61:32], 30'hFFF);

        // out-of-window base address
        @(posedge clk); #1;
        start2 = 1'b1; word_count2 = CNT_W'(1); s_valid2 = 1'b1; s_data2 = 32'hDEADBEEF;
        @(posedge clk); #1 start2 = 1'b0;
        for (int i = 0; i < 10 && !(done2 || error2); i++) begin
            @(posedge clk); #1;
            if (!s_ready2) s_valid2 = 1'b0;
        end
        s_valid2 = 1'b0;
        chk("oow_err", error2, VER);
        chk("oow_done", done2, !VER);
        chk("oow_ww", words_written2, VER ? 0 : 1);
        chk("oow_wrcnt", wr2_cnt, 1);
        chk("oow_addr", wr2_addr, 30'h0000_4000);

        // async reset after three of seven words, then a fresh 2-word load
        wds.delete();
        foreach (prog[i]) wds.push_back(prog[i]);
        run_load(7, -1, -1, 3, 0);
        #4 rst_n = 1'b1;
        wds.delete();
        wds.push_back(32'hA5A5_0001);
        wds.push_back(32'h5A5A_0002);
        run_load(2, -1, -1, -1, VER ? 7 : 3);
        chk("rec_mem2", mem[2], prog[2]);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/instr_ram_loader.md
Name: instr_ram_loader

Overview:
- Writer-side master for the instruction RAM's port B (write enable, word address, write data, registered read data).
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive word addresses from BASE_ADDR.
- Holds the CPU in reset while loading, then reports done or error.
- Sits between the debug/UART front end and the instruction RAM. Port A (fetch) is untouched.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word; bits [1:0] ignored.
- MAX_WORDS, 4096, maximum words per load; equals RAM depth.
- CNT_W, 13, width of count ports; must hold MAX_WORDS.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or ERROR.
- word_count  input  CNT_W  number of words to load; sampled on start.
- s_valid  input  1  stream word valid.
- s_data  input  32  stream instruction word.
- s_ready  output  1  loader can accept s_data this cycle.
- ram_web  output  1  port-B write enable.
- ram_addrb  output  30  port-B word address [31:2].
- ram_dinb  output  32  port-B write data.
- ram_doutb  input  32  port-B read data; valid one cycle after the address is presented.
- busy  output  1  load in progress.
- cpu_hold  output  1  keeps the CPU in reset; equal to busy.
- done  output  1  level; the load completed without error.
- error  output  1  level, sticky; the load aborted.
- words_written  output  CNT_W  words committed so far in the current load.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; index=0.
  - All outputs are 0, except ram_addrb, which resets to BASE_ADDR[31:2].
- States: IDLE, WRITE, RD, CMP, DONE, ERROR.
- start in IDLE/DONE/ERROR:
  - Clears done, error and words_written; latches word_count.
  - word_count==0: go to DONE next cycle.
  - word_count>MAX_WORDS: go to ERROR next cycle, no RAM write.
  - Otherwise: go to WRITE with busy=1.
- start while busy is ignored.
- WRITE:
  - s_ready=1.
  - ram_addrb = BASE_ADDR[31:2]+index, combinationally.
  - ram_dinb = s_data.
  - ram_web = s_valid.
  - On s_valid&s_ready: write commits at this posedge and s_data is latched into hold_data.
    - With READBACK_VERIFY_EN: go to RD.
    - Without it: index++ and words_written++; go to DONE if index+1==count, else stay in WRITE.
  - No s_valid: stay in WRITE, ram_web=0.
- RD: s_ready=0, ram_web=0, ram_addrb = same address. The RAM registers the freshly written word at this edge.
- CMP:
  - s_ready=0, ram_web=0. Compare ram_doutb with hold_data.
  - Mismatch: go to ERROR.
  - Match: index++ and words_written++; go to DONE if the new index==count, else go to WRITE.
- DONE: done=1, busy=0, cpu_hold=0. Stays until start.
- ERROR: error=1, busy=0, cpu_hold=0, ram_web=0. Stays until start.
- ram_web is never asserted outside WRITE.
- Address arithmetic is 30-bit modulo 2^30. Wrap is permitted but out-of-window addresses are dropped by the RAM, and verify then flags a mismatch (readback 0).
- Throughput: 1 word/cycle without verify; 1 word per 3 cycles with verify.
- Reset mid-load:
  - Immediate return to IDLE; the partial image stays in RAM.
  - words_written returns to 0; done=0 and error=0.

Optional Feature:
- READBACK_VERIFY_EN defined:
  - RD/CMP states exist; every word is read back and compared.
  - A mismatch raises error, and words_written counts only verified words.
- Not defined:
  - RD/CMP and hold_data compare logic are removed; WRITE runs back-to-back.
  - error only reports word_count>MAX_WORDS.

Test Plan:
- Basic load:
  - Stimulus: BASE_ADDR=0, start with word_count=7, stream 32'h00000293, 32'h00000313, 32'h06500393, 32'h00530333, 32'h00128293, 32'hfe729ce3, 32'h00130313 with s_valid held high.
  - Response: ram_web pulses at word addresses 0..6; done=1; words_written=7; cpu_hold falls with done; RAM words 0..6 match the stream.
  - Cycle count from start: 8 cycles without verify, 22 with verify.
- Bubbles and latency:
  - Stimulus: deassert s_valid for 3 cycles between words 2 and 3.
  - Response: ram_web=0 and ram_addrb held during the gap; final image identical.
  - With verify: s_ready low for exactly 2 cycles after each accepted word.
- Boundaries:
  - word_count=0: done=1 the cycle after start, no ram_web.
  - word_count=4097: error=1, no ram_web.
  - word_count=4096 with BASE_ADDR=0: last write at addrb=12'hFFF, done=1.
- Verify failure (READBACK_VERIFY_EN):
  - Stimulus: BASE_ADDR=32'h0001_0000 (outside RAM window), load 1 word 32'hDEADBEEF.
  - Response: readback 0 gives error=1 and words_written=0.
- Async reset mid-load:
  - Stimulus: pull rst_n low after word 3 of 7, asynchronously between edges.
  - Response: busy, cpu_hold, ram_web and s_ready fall immediately; a subsequent start with word_count=2 loads words at addresses 0 and 1 and sets done.
- Start while busy: a pulse mid-load is ignored; count, addresses and done timing are unchanged.
